// File: rtl/mem_fill_arbiter.sv
// Shared main-memory sequencer: I/D cache block fills and D-side write-through stores.
module mem_fill_arbiter #(
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned MEM_LATENCY     = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_miss,
  input  logic [15:0]                        i_miss_addr,
  input  logic                               d_miss,
  input  logic [15:0]                        d_miss_addr,
  input  logic                               d_wr,
  input  logic [15:0]                        d_wr_addr,
  input  logic [15:0]                        d_wr_data,
  output logic [15:0]                        mem_addr,
  output logic                               mem_enable,
  output logic                               mem_wr,
  output logic [15:0]                        mem_data_in,
  input  logic [15:0]                        mem_data_out,
  input  logic                               mem_data_valid,
  output logic [15:0]                        fill_data,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
  output logic                               i_fill_we,
  output logic                               d_fill_we,
  output logic                               i_done,
  output logic                               d_done,
  output logic                               d_wr_done,
  output logic                               busy
);

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned WORD_IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned CNT_W      = WORD_IDX_W + 1;
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FILL  = 2'd2
  } state_t;

  state_t                  state;
  logic                    owner_d;
  logic [ADDR_W-1:0]       base;
  logic [CNT_W-1:0]        issue_cnt;
  logic [WORD_IDX_W-1:0]   ret_cnt;

  logic                    issuing_c;
  logic                    ret_accept_c;
  logic                    ret_last_c;

  // Returns are tracked by mem_data_valid, so the latency only documents the memory contract.
  logic [31:0] unused_mem_latency;
  assign unused_mem_latency = 32'(MEM_LATENCY);

  // Issue phase covers the first WORDS_PER_BLOCK FILL cycles; a return is only
  // accepted while a read of this fill is still outstanding.
  assign issuing_c    = (state == FILL) && (issue_cnt < CNT_W'(WORDS_PER_BLOCK));
  assign ret_accept_c = (state == FILL) && mem_data_valid && ({1'b0, ret_cnt} < issue_cnt);
  assign ret_last_c   = ret_accept_c && (ret_cnt == WORD_IDX_W'(WORDS_PER_BLOCK - 1));

  // State, owner, block base and issue/return counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      base      <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          issue_cnt <= '0;
          ret_cnt   <= '0;
          if (d_wr) begin
            state <= WRITE;
          end else if (d_miss) begin
            state   <= FILL;
            owner_d <= 1'b1;
            base    <= d_miss_addr & ~OFFSET_MASK;
          end else if (i_miss) begin
            state   <= FILL;
            owner_d <= 1'b0;
            base    <= i_miss_addr & ~OFFSET_MASK;
          end
        end
        WRITE: begin
          state <= IDLE;
        end
        FILL: begin
          if (issuing_c) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
          end
          if (ret_accept_c) begin
            ret_cnt <= ret_cnt + WORD_IDX_W'(1);
            if (ret_last_c) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode; everything reads zero while reset is asserted and in IDLE.
  always_comb begin
    mem_addr    = '0;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_data_in = '0;
    fill_data   = '0;
    fill_word   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_done      = 1'b0;
    d_done      = 1'b0;
    d_wr_done   = 1'b0;
    busy        = 1'b0;
    if (rst_n) begin
      case (state)
        WRITE: begin
          busy        = 1'b1;
          mem_enable  = 1'b1;
          mem_wr      = 1'b1;
          mem_addr    = d_wr_addr;
          mem_data_in = d_wr_data;
          d_wr_done   = 1'b1;
        end
        FILL: begin
          busy = 1'b1;
          if (issuing_c) begin
            mem_enable = 1'b1;
            mem_addr   = base + ADDR_W'({issue_cnt[WORD_IDX_W-1:0], 1'b0});
          end
          if (ret_accept_c) begin
            fill_data = mem_data_out;
            fill_word = ret_cnt;
            i_fill_we = !owner_d;
            d_fill_we = owner_d;
            i_done    = ret_last_c && !owner_d;
            d_done    = ret_last_c && owner_d;
          end
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with a fixed-latency memory model.
module tb_mem_fill_arbiter;

  localparam int unsigned WPB     = 8;
  localparam int unsigned LAT     = 4;
  localparam int unsigned WORD_W  = 3;
  localparam int unsigned NVEC    = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss;
  logic [15:0] i_miss_addr;
  logic        d_miss;
  logic [15:0] d_miss_addr;
  logic        d_wr;
  logic [15:0] d_wr_addr;
  logic [15:0] d_wr_data;
  logic [15:0] mem_addr;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out = 16'h0;
  logic        mem_data_valid = 1'b0;
  logic [15:0] fill_data;
  logic [WORD_W-1:0] fill_word;
  logic        i_fill_we;
  logic        d_fill_we;
  logic        i_done;
  logic        d_done;
  logic        d_wr_done;
  logic        busy;

  logic        stray_valid;
  int          checks = 0;
  int          errors = 0;

  mem_fill_arbiter #(
    .WORDS_PER_BLOCK(WPB),
    .MEM_LATENCY    (LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_miss        (i_miss),
    .i_miss_addr   (i_miss_addr),
    .d_miss        (d_miss),
    .d_miss_addr   (d_miss_addr),
    .d_wr          (d_wr),
    .d_wr_addr     (d_wr_addr),
    .d_wr_data     (d_wr_data),
    .mem_addr      (mem_addr),
    .mem_enable    (mem_enable),
    .mem_wr        (mem_wr),
    .mem_data_in   (mem_data_in),
    .mem_data_out  (mem_data_out),
    .mem_data_valid(mem_data_valid),
    .fill_data     (fill_data),
    .fill_word     (fill_word),
    .i_fill_we     (i_fill_we),
    .d_fill_we     (d_fill_we),
    .i_done        (i_done),
    .d_done        (d_done),
    .d_wr_done     (d_wr_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_model(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // Memory: reads seen in cycle c return, in order, during cycle c+LAT.
  logic [LAT-1:0]       vpipe = '0;
  logic [LAT-1:0][15:0] dpipe = '0;

  always @(negedge clk) begin
    vpipe <= {mem_enable && !mem_wr, vpipe[LAT-1:1]};
    dpipe <= {mem_model(mem_addr), dpipe[LAT-1:1]};
  end

  always @(posedge clk) begin
    #1;
    mem_data_valid <= vpipe[0] | stray_valid;
    mem_data_out   <= vpipe[0] ? dpipe[0] : (stray_valid ? 16'hDEAD : 16'h0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input string sig, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s act=%h req=%h t=%0t", tag, sig, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag,
                               input logic e_busy, e_en, e_wr,
                               input logic [15:0] e_addr, e_din,
                               input logic e_ifwe, e_dfwe,
                               input logic [15:0] e_fdata,
                               input logic [WORD_W-1:0] e_fword,
                               input logic e_idone, e_ddone, e_wdone);
    chk(tag, "busy", 16'(busy), 16'(e_busy));
    chk(tag, "mem_enable", 16'(mem_enable), 16'(e_en));
    chk(tag, "mem_wr", 16'(mem_wr), 16'(e_wr));
    if (e_en || !e_busy) chk(tag, "mem_addr", mem_addr, e_addr);
    if (e_wr || !e_busy) chk(tag, "mem_data_in", mem_data_in, e_din);
    chk(tag, "i_fill_we", 16'(i_fill_we), 16'(e_ifwe));
    chk(tag, "d_fill_we", 16'(d_fill_we), 16'(e_dfwe));
    if (e_ifwe || e_dfwe || !e_busy) begin
      chk(tag, "fill_data", fill_data, e_fdata);
      chk(tag, "fill_word", 16'(fill_word), 16'(e_fword));
    end
    chk(tag, "i_done", 16'(i_done), 16'(e_idone));
    chk(tag, "d_done", 16'(d_done), 16'(e_ddone));
    chk(tag, "d_wr_done", 16'(d_wr_done), 16'(e_wdone));
  endtask

  // Entered just before the sampling cycle T of an already-raised request;
  // checks T..T+12 and drops the owner's request after done.
  task automatic expect_fill(input string name, input bit own_d, input logic [15:0] base, input int wr_at);
    logic [15:0] ia;
    logic [15:0] ra;
    logic        fwe;
    @(negedge clk);
    check_outputs({name, "_T0"}, 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, '0, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      ia  = base + 16'(2 * (k - 1));
      ra  = base + 16'(2 * (k - 5));
      fwe = (k >= 5);
      check_outputs($sformatf("%s_T%0d", name, k), 1'b1, (k <= 8), 1'b0,
                    (k <= 8) ? ia : 16'h0, 16'h0,
                    fwe && !own_d, fwe && own_d,
                    fwe ? mem_model(ra) : 16'h0,
                    fwe ? WORD_W'(k - 5) : '0,
                    (k == 12) && !own_d, (k == 12) && own_d, 1'b0);
      if (k == wr_at) begin
        d_wr      = 1'b1;
        d_wr_addr = 16'h0AB0;
        d_wr_data = 16'hC0DE;
      end
    end
    if (own_d) d_miss = 1'b0;
    else       i_miss = 1'b0;
  endtask

  typedef struct {
    logic        rst_n;
    logic        d_wr;
    logic [15:0] wa;
    logic [15:0] wd;
    logic        d_miss;
    logic [15:0] dma;
    logic        exp_busy;
    logic        exp_en;
    logic        exp_wr;
    logic [15:0] exp_addr;
    logic [15:0] exp_din;
    logic        exp_wdone;
  } vec_t;

  vec_t vecs [NVEC];

  initial begin
    rst_n = 1'b0; i_miss = 1'b0; i_miss_addr = 16'h0;
    d_miss = 1'b0; d_miss_addr = 16'h0;
    d_wr = 1'b0; d_wr_addr = 16'h0; d_wr_data = 16'h0;
    stray_valid = 1'b0;

    // One record per cycle: inputs held for the cycle, outputs expected in it.
    vecs[0]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 16'h0100, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 16'h7FFE, 16'h1234, 1'b1, 16'h005C, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 16'h7FFE, 16'h1234, 1'b1, 16'h005C, 1'b1, 1'b1, 1'b1, 16'h7FFE, 16'h1234, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h005C, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h005C, 1'b1, 1'b1, 1'b0, 16'h0050, 16'h0000, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};

    @(posedge clk); #1;
    for (int v = 0; v < NVEC; v++) begin
      rst_n       = vecs[v].rst_n;
      d_wr        = vecs[v].d_wr;
      d_wr_addr   = vecs[v].wa;
      d_wr_data   = vecs[v].wd;
      d_miss      = vecs[v].d_miss;
      d_miss_addr = vecs[v].dma;
      @(negedge clk);
      check_outputs($sformatf("vec%0d", v), vecs[v].exp_busy, vecs[v].exp_en, vecs[v].exp_wr,
                    vecs[v].exp_addr, vecs[v].exp_din, 1'b0, 1'b0, 16'h0, '0,
                    1'b0, 1'b0, vecs[v].exp_wdone);
      @(posedge clk); #1;
    end

    // Plain I fill with a non-zero word offset.
    i_miss = 1'b1; i_miss_addr = 16'h123A;
    expect_fill("ifill", 1'b0, 16'h1230, 0);

    // Simultaneous D and I misses: D first, then I after one IDLE re-sample.
    @(posedge clk); #1;
    d_miss = 1'b1; d_miss_addr = 16'h00F4;
    i_miss = 1'b1; i_miss_addr = 16'h4000;
    expect_fill("dfirst", 1'b1, 16'h00F0, 0);
    expect_fill("ithen", 1'b0, 16'h4000, 0);

    // Store raised mid-fill waits for the fill, one IDLE cycle, then WRITE.
    @(posedge clk); #1;
    i_miss = 1'b1; i_miss_addr = 16'h8886;
    expect_fill("wrwait", 1'b0, 16'h8880, 3);
    @(negedge clk);
    check_outputs("wr_gap", 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, '0, 0, 0, 0);
    @(negedge clk);
    check_outputs("wr_issue", 1, 1, 1, 16'h0AB0, 16'hC0DE, 0, 0, 16'h0, '0, 0, 0, 1);
    d_wr = 1'b0;
    @(negedge clk);
    check_outputs("wr_after", 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, '0, 0, 0, 0);

    // Reset in the middle of a D fill, with stray returns afterwards.
    @(posedge clk); #1;
    d_miss = 1'b1; d_miss_addr = 16'h2468;
    @(negedge clk);
    check_outputs("rst_T0", 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, '0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check_outputs($sformatf("rst_T%0d", k), 1'b1, 1'b1, 1'b0, 16'h2460 + 16'(2 * (k - 1)), 16'h0,
                    1'b0, (k == 5), (k == 5) ? mem_model(16'h2460) : 16'h0, '0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b0; d_miss = 1'b0;
    for (int k = 6; k <= 11; k++) begin
      @(negedge clk);
      check_outputs($sformatf("rst_T%0d", k), 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, '0, 0, 0, 0);
      if (k == 6)  begin rst_n = 1'b1; stray_valid = 1'b1; end
      if (k == 10) stray_valid = 1'b0;
    end

    // Fresh D fill after the abandoned one.
    @(posedge clk); #1;
    d_miss = 1'b1; d_miss_addr = 16'h2468;
    expect_fill("dafter", 1'b1, 16'h2460, 0);

    // Top-of-address-space block: no carry out of the offset bits.
    @(posedge clk); #1;
    i_miss = 1'b1; i_miss_addr = 16'hFFF6;
    expect_fill("wrap", 1'b0, 16'hFFF0, 0);
    @(negedge clk);
    check_outputs("final_idle", 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, '0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
- Sequences the single shared multi-cycle main memory between the instruction-cache miss path, the data-cache miss path and data-side write-through stores.
- On a miss it fetches a whole 16-byte block as 8 back-to-back word reads and streams the returned words into the requesting cache's fill port.
- Sits between both caches and the main memory model; the pipeline stalls on the caches' miss signals until done is pulsed.

Parameters:
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; a power of two; sets the block size to 2*WORDS_PER_BLOCK bytes.
- MEM_LATENCY, 4, cycles from a read issue (mem_enable=1, mem_wr=0) to the matching mem_data_valid.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- i_miss  input  1  I-cache miss request; level, held until i_done.
- i_miss_addr  input  16  I-side byte address of the missing word.
- d_miss  input  1  D-cache miss request; level, held until d_done.
- d_miss_addr  input  16  D-side byte address of the missing word.
- d_wr  input  1  D-side write-through store request; level, held until d_wr_done.
- d_wr_addr  input  16  store byte address.
- d_wr_data  input  16  store data.
- mem_addr  output  16  main memory byte address.
- mem_enable  output  1  main memory access strobe.
- mem_wr  output  1  main memory write strobe.
- mem_data_in  output  16  main memory write data.
- mem_data_out  input  16  main memory read data.
- mem_data_valid  input  1  read data valid.
- fill_data  output  16  returned word, driven to both caches.
- fill_word  output  log2(WORDS_PER_BLOCK)  index of the returned word within the block.
- i_fill_we  output  1  write fill_data into the I-cache.
- d_fill_we  output  1  write fill_data into the D-cache.
- i_done  output  1  one-cycle pulse: I-side fill complete.
- d_done  output  1  one-cycle pulse: D-side fill complete.
- d_wr_done  output  1  one-cycle pulse: store accepted by memory.
- busy  output  1  1 whenever state != IDLE.

Behaviour:
- FSM states: IDLE, WRITE, FILL. Registers: owner (I/D), base address, issue count, return count.
- Reset (rst_n=0 at a clk edge) forces IDLE and clears all counters.
  - All outputs read 0 during reset and in IDLE; fill_data and fill_word also read 0.
  - Reset mid-FILL abandons the fill; no done pulse is generated.
  - mem_data_valid arriving after reset, or in any state other than FILL, is ignored.
- IDLE, requests sampled every cycle with fixed priority d_wr > d_miss > i_miss:
  - d_wr -> WRITE.
  - d_miss -> FILL with owner=D, base={d_miss_addr[15:4],4'b0}.
  - i_miss -> FILL with owner=I, base from i_miss_addr the same way.
  - Nothing is issued to memory in the sampling cycle.
- WRITE lasts exactly one cycle:
  - mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_in=d_wr_data, d_wr_done=1.
  - Next state IDLE.
- FILL, issue side:
  - For the first WORDS_PER_BLOCK cycles, mem_enable=1, mem_wr=0, mem_addr=base+2*issue_count.
  - issue_count runs 0..WORDS_PER_BLOCK-1.
- FILL, return side:
  - On each mem_data_valid: fill_data=mem_data_out, fill_word=return_count, and the owner's fill_we=1 in the same cycle (combinational pass-through). return_count increments.
  - Words return in issue order.
  - On the last return (return_count==WORDS_PER_BLOCK-1): the owner's done pulses in that same cycle; next state IDLE.
- Timing: a request first seen in IDLE at cycle T gives issues at T+1..T+8, returns at T+5..T+12, done at T+12 and IDLE at T+13 (defaults).
- The requester must drop its request the cycle after done. A request still high at T+13 is treated as a new miss.
- Requests arriving during WRITE or FILL are not acknowledged; they are sampled on the next IDLE cycle.
- There is no back-to-back turnaround: at least one IDLE cycle separates any two transactions.
- Simultaneous d_miss and i_miss: D is served first, then I via the IDLE re-sample. Total i_done latency = 2 fills + 2 idle cycles.
- Address arithmetic is 16-bit wrapping. The offset bits addr[3:0] of the requester never affect the issued addresses.

Test Plan:
- Reset, then i_miss=1 with i_miss_addr=0x123A at cycle T:
  - mem_addr=0x1230,0x1232,...,0x123E at T+1..T+8.
  - Eight i_fill_we pulses at T+5..T+12 with fill_word 0..7 and data matching memory.
  - i_done pulses at T+12; d_fill_we stays 0 throughout.
- d_miss with addr 0x00F4 and i_miss with addr 0x4000 asserted in the same cycle:
  - Full D fill of 0x00F0-0x00FE completes first with d_done.
  - Then the I fill of 0x4000-0x400E starts and completes with i_done.
- d_wr with addr 0x0100, data 0xBEEF while idle:
  - One cycle of mem_enable=1, mem_wr=1, mem_addr=0x0100, mem_data_in=0xBEEF with d_wr_done=1; busy returns to 0 the next cycle.
- d_wr asserted at T+3 of an I fill:
  - No memory write until i_done.
  - The write is issued exactly 2 cycles after i_done (one IDLE cycle, then WRITE); no fill data is lost.
- rst_n=0 at T+6 of a D fill:
  - All outputs 0 from the reset edge; no d_done.
  - Stray mem_data_valid at T+7..T+10 produces no fill_we.
  - A fresh d_miss after reset performs a complete, correct fill.
- Wrap case, i_miss_addr=0xFFF6:
  - Issued addresses 0xFFF0..0xFFFE; fill_word 0..7; no carry into higher bits.
